signed_bcd_display: RTL and testbench
=====================================

Name: signed_bcd_display

Overview:
Display-side consumer of the four-digit signed counter. It samples the counter's 16-bit binary magnitude and sign-flag pair and converts the magnitude to four BCD digits with an iterative shift-add-3 engine. It then drives a time-multiplexed, common-anode, four-digit seven-segment display plus a separate minus LED. It sits between the counter and the board pins.

Parameters:
REFRESH_DIV, 50000, clocks each digit stays lit before the scan advances; legal range is 2 or more.
BLANK_LZ, 1, when 1, leading zeros are blanked on digits 3..1; the ones digit is never blanked.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Q  input  16  binary magnitude from the counter; nominal range 0..9999, any 16-bit value accepted.
sign  input  1  1 = positive, 0 = negative; same encoding as the counter's sign output.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
an  output  4  digit anodes, active-low one-hot, registered; an[0] = ones, an[3] = thousands.
neg_led  output  1  1 = show minus sign; registered.
ovf  output  1  1 = last converted magnitude exceeded 9999; registered.
conv_done  output  1  one-cycle pulse in the cycle the display digit registers are updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - Shift/BCD working registers, iteration count, display digits d3..d0, refresh counter and scan index are all cleared to 0.
  - seg=7'h7F, an=4'b1111, neg_led=0, ovf=0, conv_done=0.
  - Releasing reset mid-conversion restarts from IDLE; a partial result is never latched.
- Conversion FSM, free-running and restarting continuously:
  - IDLE, 1 cycle: capture Q into the shift register and sign into a shadow register; clear the BCD accumulator; count=0; go to SHIFT.
  - SHIFT, 16 cycles: on each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, shift} left by one. Inputs are ignored during SHIFT. After count reaches 15, go to LATCH.
  - LATCH, 1 cycle:
    - If the captured Q > 9999: ovf<=1 and the digits are left unchanged.
    - Otherwise: ovf<=0, d3..d0<=BCD result, neg_led<=~sign_shadow AND (Q_shadow!=0), so that minus-zero shows as positive.
    - conv_done=1 in this cycle; then go to IDLE.
  - Period is 18 cycles: a change on Q appears at most 36 cycles later.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - When it reaches terminal count it wraps to 0 and the scan index increments modulo 4, in order 0,1,2,3,0.
  - The scan is independent of the conversion FSM.
- Output register, updated every cycle from the current scan index:
  - an <= ~(1<<idx).
  - seg value is chosen by priority:
    - ovf=1: dash, 7'h3F, on every digit.
    - BLANK_LZ=1, idx>0 and d[idx..3] all zero: blank, 7'h7F.
    - Otherwise the digit code.
  - One-cycle latency from an index or digit change to the pins.
- Digit codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19.
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Non-BCD nibbles, unreachable, show blank.
- Simultaneous events: a LATCH in the same cycle as a scan advance uses the new digits on the following cycle. There is no tearing, because all four digits update in one edge.

Test Plan:
1. Q=1234, sign=1, REFRESH_DIV=4, run 40 cycles.
   - Required: conv_done pulses every 18 cycles; ovf=0; neg_led=0.
   - an cycles through 1110, 1101, 1011, 0111 with seg 19, 30, 24, 79 respectively, 4 cycles each.
2. Q=7, sign=0.
   - Required: neg_led=1; an[3:1] slots show seg 7F; ones slot shows 78.
   - Repeat with BLANK_LZ=0: thousands, hundreds and tens show 40.
3. Q=0, sign=0.
   - Required: neg_led=0; ones slot shows 40; other slots show 7F.
4. Q=10005, then Q=9999, sign=1.
   - First: ovf=1 and all slots show 3F.
   - Within 36 cycles of Q=9999: ovf=0 and all slots show 10.
5. Change Q from 1111 to 2222 during the SHIFT phase.
   - Required: the next conv_done still latches 1111; the following conv_done latches 2222.
6. Assert reset mid-SHIFT while an=1011.
   - Required: immediately an=1111, seg=7F, neg_led=0, ovf=0.
   - After release: first conv_done 18 cycles later with a correct value.

Source files
------------

// File: rtl/signed_bcd_display.sv
// Signed four-digit display driver: samples a binary magnitude and sign, converts it to BCD
// with a free-running shift-add-3 engine, and scans a common-anode seven-segment display.
module signed_bcd_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Q,
    input  logic        sign,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        neg_led,
    output logic        ovf,
    output logic        conv_done
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t          r_state;
    logic [15:0]     r_shift;
    logic [15:0]     r_bcd;
    logic [15:0]     r_q_shadow;
    logic            r_sign_shadow;
    logic [3:0]      r_count;
    logic [3:0][3:0] r_digits;
    logic            r_neg_led;
    logic            r_ovf;
    logic            r_conv_done;

    logic [RW-1:0]   r_refresh;
    logic [1:0]      r_idx;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;

    logic [15:0]     w_bcd_adj;
    logic [3:0]      w_upper_zero;
    logic [3:0]      w_cur_digit;
    logic            w_blank;
    logic [6:0]      w_seg_next;

    // Add-3 correction for every nibble that would reach 10 or more after the next shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
            assign w_upper_zero[gi] = (r_digits[3:gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bcd         <= '0;
            r_q_shadow    <= '0;
            r_sign_shadow <= 1'b0;
            r_count       <= '0;
            r_digits      <= '0;
            r_neg_led     <= 1'b0;
            r_ovf         <= 1'b0;
            r_conv_done   <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_shift       <= Q;
                    r_q_shadow    <= Q;
                    r_sign_shadow <= sign;
                    r_bcd         <= '0;
                    r_count       <= '0;
                    r_state       <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj[14:0], r_shift, 1'b0};
                    r_count          <= r_count + 4'd1;
                    if (r_count == 4'd15) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_q_shadow > 16'd9999) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_ovf     <= 1'b0;
                        r_digits  <= r_bcd;
                        // Minus zero is shown as plain zero.
                        r_neg_led <= ~r_sign_shadow & (r_q_shadow != 16'd0);
                    end
                    r_conv_done <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == REFRESH_TC) begin
            r_refresh <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

    assign w_cur_digit = r_digits[r_idx];
    assign w_blank     = BLANK_LZ && (r_idx != 2'd0) && w_upper_zero[r_idx];

    always_comb begin
        w_seg_next = 7'h7F;
        if (r_ovf) begin
            w_seg_next = 7'h3F;
        end else if (w_blank) begin
            w_seg_next = 7'h7F;
        end else begin
            case (w_cur_digit)
                4'd0:    w_seg_next = 7'h40;
                4'd1:    w_seg_next = 7'h79;
                4'd2:    w_seg_next = 7'h24;
                4'd3:    w_seg_next = 7'h30;
                4'd4:    w_seg_next = 7'h19;
                4'd5:    w_seg_next = 7'h12;
                4'd6:    w_seg_next = 7'h02;
                4'd7:    w_seg_next = 7'h78;
                4'd8:    w_seg_next = 7'h00;
                4'd9:    w_seg_next = 7'h10;
                default: w_seg_next = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= 7'h7F;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign neg_led   = r_neg_led;
    assign ovf       = r_ovf;
    assign conv_done = r_conv_done;

endmodule

// File: tb/tb_signed_bcd_display.sv
// Directed bench for signed_bcd_display: a vector table of magnitudes/signs with expected
// per-slot segment codes, plus sequences for latency, mid-conversion input change and reset.
module tb_signed_bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] Q = 16'd1234;
    logic        sign = 1'b1;
    logic [6:0]  seg, seg_nb;
    logic [3:0]  an, an_nb;
    logic        neg_led, neg_nb;
    logic        ovf, ovf_nb;
    logic        conv_done, done_nb;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    signed_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .Q(Q), .sign(sign),
        .seg(seg), .an(an), .neg_led(neg_led), .ovf(ovf), .conv_done(conv_done)
    );

    signed_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .Q(Q), .sign(sign),
        .seg(seg_nb), .an(an_nb), .neg_led(neg_nb), .ovf(ovf_nb), .conv_done(done_nb)
    );

    typedef struct packed {
        logic [15:0]     q;
        logic            s;
        logic [3:0][6:0] lz;   // [3]=thousands .. [0]=ones, leading-zero blanking on
        logic [3:0][6:0] nb;   // same, blanking off
        logic            neg;
        logic            ovf;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] q, input logic s, input logic [27:0] lz,
                                input logic [27:0] nb, input logic neg, input logic ov);
        vec_t v;
        v.q = q; v.s = s; v.lz = lz; v.nb = nb; v.neg = neg; v.ovf = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!conv_done && cyc < 100);
        chk("conv_done_seen", 32'(conv_done), 32'd1);
    endtask

    task automatic scan(output logic [3:0][6:0] slz, output logic [3:0][6:0] snb,
                        output logic [15:0] dwell);
        int slot;
        slz = '0; snb = '0; dwell = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            case (an)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            if (slot >= 0) begin
                slz[slot] = seg;
                snb[slot] = seg_nb;
                dwell[slot*4 +: 4] = dwell[slot*4 +: 4] + 4'd1;
            end
        end
    endtask

    task automatic check_slots(input string tag, input vec_t v, input logic [3:0][6:0] slz,
                               input logic [3:0][6:0] snb);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_seg_slot%0d", tag, k), 32'(slz[k]), 32'(v.lz[k]));
            chk($sformatf("%s_segnb_slot%0d", tag, k), 32'(snb[k]), 32'(v.nb[k]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs[11];
        vec_t            v;
        logic [3:0][6:0] slz, snb;
        logic [15:0]     dwell;
        int              cyc;

        vecs[0]  = mk(16'd1234,  1'b1, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 1'b0, 1'b0);
        vecs[1]  = mk(16'd7,     1'b0, {7'h7F,7'h7F,7'h7F,7'h78}, {7'h40,7'h40,7'h40,7'h78}, 1'b1, 1'b0);
        vecs[2]  = mk(16'd0,     1'b0, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}, 1'b0, 1'b0);
        vecs[3]  = mk(16'd10005, 1'b1, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b0, 1'b1);
        vecs[4]  = mk(16'd9999,  1'b1, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1'b0, 1'b0);
        vecs[5]  = mk(16'd10000, 1'b0, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b0, 1'b1);
        vecs[6]  = mk(16'd1000,  1'b0, {7'h79,7'h40,7'h40,7'h40}, {7'h79,7'h40,7'h40,7'h40}, 1'b1, 1'b0);
        vecs[7]  = mk(16'd905,   1'b1, {7'h7F,7'h10,7'h40,7'h12}, {7'h40,7'h10,7'h40,7'h12}, 1'b0, 1'b0);
        vecs[8]  = mk(16'd50,    1'b0, {7'h7F,7'h7F,7'h12,7'h40}, {7'h40,7'h40,7'h12,7'h40}, 1'b1, 1'b0);
        vecs[9]  = mk(16'd0,     1'b1, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}, 1'b0, 1'b0);
        vecs[10] = mk(16'd65535, 1'b0, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b0, 1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_neg", 32'(neg_led), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(conv_done), 32'd0);
        $display("reset: seg=%h an=%b neg=%b ovf=%b", seg, an, neg_led, ovf);

        // Latency, period and pulse width with Q=1234
        reset = 1'b1;
        wait_done(cyc);
        chk("first_latency", 32'(cyc), 32'd18);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", 32'(conv_done), 32'd0);
        wait_done(cyc);
        chk("conv_period", 32'(cyc + 1), 32'd18);
        scan(slz, snb, dwell);
        chk("slot_dwell", 32'(dwell), 32'h4444);
        $display("period check: period=%0d dwell=%h", cyc + 1, dwell);

        // Table of magnitudes and signs
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            Q = v.q;
            sign = v.s;
            wait_done(cyc);
            wait_done(cyc);
            scan(slz, snb, dwell);
            check_slots($sformatf("v%0d", i), v, slz, snb);
            chk($sformatf("v%0d_neg", i), 32'(neg_led), 32'(v.neg));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(v.ovf));
            chk($sformatf("v%0d_negnb", i), 32'(neg_nb), 32'(v.neg));
            chk($sformatf("v%0d_dwell", i), 32'(dwell), 32'h4444);
            $display("vec %0d: Q=%0d sign=%b seg_slots=%h nb_slots=%h neg=%b ovf=%b",
                     i, v.q, v.s, slz, snb, neg_led, ovf);
        end

        // Overflow recovery within two conversion periods
        Q = 16'd10005; sign = 1'b1;
        wait_done(cyc);
        wait_done(cyc);
        chk("ovf_set", 32'(ovf), 32'd1);
        Q = 16'd9999;
        cyc = 0;
        while (ovf && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("ovf_clear_within_36", 32'(cyc <= 36 && !ovf), 32'd1);
        $display("ovf recovery: cycles=%0d ovf=%b", cyc, ovf);

        // Q change during SHIFT must not affect the conversion in flight
        Q = 16'd1111; sign = 1'b1;
        wait_done(cyc);
        wait_done(cyc);
        repeat (3) @(negedge clk);
        Q = 16'd2222;
        wait_done(cyc);
        scan(slz, snb, dwell);
        check_slots("midshift_old", mk(16'd1111, 1'b1, {4{7'h79}}, {4{7'h79}}, 1'b0, 1'b0), slz, snb);
        wait_done(cyc);
        scan(slz, snb, dwell);
        check_slots("midshift_new", mk(16'd2222, 1'b1, {4{7'h24}}, {4{7'h24}}, 1'b0, 1'b0), slz, snb);
        $display("midshift change: second latch slots=%h", slz);

        // Asynchronous reset mid-SHIFT while the hundreds slot is lit
        Q = 16'd7; sign = 1'b0;
        wait_done(cyc);
        wait_done(cyc);
        chk("pre_rst_neg", 32'(neg_led), 32'd1);
        wait_done(cyc);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 2 && an == 4'b1011) break;
        end
        chk("found_an_1011", 32'(an), 32'hB);
        reset = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_neg", 32'(neg_led), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_done(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd18);
        scan(slz, snb, dwell);
        check_slots("post_rst", vecs[1], slz, snb);
        chk("post_rst_neg", 32'(neg_led), 32'd1);
        $display("reset mid-shift: latency=%0d slots=%h neg=%b", cyc, slz, neg_led);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
